// File: rtl/inst_fetcher.sv
// Instruction fetch front end: holds the PC, requests instructions from the
// icache, predicts the next PC (JAL always taken, conditional branches from a
// 2-bit bimodal BHT), buffers fetched instructions in a small circular queue
// and issues one registered instruction per cycle to the decoder.
//
// Handshakes: icache_req is a request-valid and icache_hit is a same-cycle
// response-valid; a fetch completes on the edge where both are high. inst_rdy
// is a one-cycle valid pulse per instruction with no ready return; the
// rs_full/lsb_full/rob_full inputs act as the "not ready" side and are
// sampled before the pulse is generated.
module inst_fetcher #(
  parameter int          IQ_DEPTH = 4,
  parameter int          BHT_SIZE = 256,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rdy,
  input  logic        rollback,
  input  logic [31:0] rollback_pc,
  output logic        icache_req,
  output logic [31:0] icache_addr,
  input  logic        icache_hit,
  input  logic [31:0] icache_inst,
  output logic        inst_rdy,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        inst_pred_jump,
  input  logic        rs_full,
  input  logic        lsb_full,
  input  logic        rob_full,
  input  logic        br_upd,
  input  logic [31:0] br_upd_pc,
  input  logic        br_upd_jump
);

  localparam int QW = (IQ_DEPTH > 1) ? $clog2(IQ_DEPTH) : 1;
  localparam int BW = (BHT_SIZE > 1) ? $clog2(BHT_SIZE) : 1;
  localparam logic [QW:0] IQ_FULL = (QW+1)'(IQ_DEPTH);

  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BR  = 7'b1100011;

  logic [31:0]   pc;
  logic [QW-1:0] head;
  logic [QW-1:0] tail;
  logic [QW:0]   count;

  logic [31:0] q_inst [IQ_DEPTH];
  logic [31:0] q_pc   [IQ_DEPTH];
  logic        q_pred [IQ_DEPTH];

  logic [1:0] bht [BHT_SIZE];

  logic [BW-1:0] fetch_idx;
  logic [BW-1:0] upd_idx;
  logic [31:0]   j_imm;
  logic [31:0]   b_imm;
  logic          pred;
  logic [31:0]   next_pc;
  logic          enq;
  logic          deq;

  assign icache_addr = pc;
  assign icache_req  = rdy & ~rollback & (count < IQ_FULL);

  assign enq = icache_req & icache_hit;
  assign deq = rdy & ~rollback & (count != '0) & ~rs_full & ~lsb_full & ~rob_full;

  assign fetch_idx = pc[BW+1:2];
  assign upd_idx   = br_upd_pc[BW+1:2];

  assign j_imm = {{12{icache_inst[31]}}, icache_inst[19:12], icache_inst[20],
                  icache_inst[30:21], 1'b0};
  assign b_imm = {{20{icache_inst[31]}}, icache_inst[7], icache_inst[30:25],
                  icache_inst[11:8], 1'b0};

  // Next-PC prediction from the instruction arriving this cycle; JALR and all
  // non-control instructions fall through to pc+4.
  always_comb begin
    pred    = 1'b0;
    next_pc = pc + 32'd4;
    if (icache_inst[6:0] == OP_JAL) begin
      pred    = 1'b1;
      next_pc = pc + j_imm;
    end else if (icache_inst[6:0] == OP_BR) begin
      if (bht[fetch_idx][1]) begin
        pred    = 1'b1;
        next_pc = pc + b_imm;
      end
    end
  end

  // Queue payload storage; validity is tracked by count, so no reset is needed.
  always_ff @(posedge clk) begin
    if (enq) begin
      q_inst[tail] <= icache_inst;
      q_pc[tail]   <= pc;
      q_pred[tail] <= pred;
    end
  end

  // PC, queue pointers and registered issue outputs; rollback wins over
  // fetch and issue, and nothing but inst_rdy moves while rdy is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc             <= RESET_PC;
      head           <= '0;
      tail           <= '0;
      count          <= '0;
      inst_rdy       <= 1'b0;
      inst           <= 32'h0;
      inst_pc        <= 32'h0;
      inst_pred_jump <= 1'b0;
    end else begin
      inst_rdy <= 1'b0;
      if (rdy) begin
        if (rollback) begin
          pc    <= rollback_pc;
          head  <= '0;
          tail  <= '0;
          count <= '0;
        end else begin
          if (enq) begin
            pc   <= next_pc;
            tail <= tail + QW'(1);
          end
          if (deq) begin
            inst           <= q_inst[head];
            inst_pc        <= q_pc[head];
            inst_pred_jump <= q_pred[head];
            inst_rdy       <= 1'b1;
            head           <= head + QW'(1);
          end
          if (enq && !deq) begin
            count <= count + (QW+1)'(1);
          end else if (!enq && deq) begin
            count <= count - (QW+1)'(1);
          end
        end
      end
    end
  end

  // Bimodal BHT: 2-bit saturating counters trained by committed branches;
  // a same-cycle lookup reads the pre-update value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BHT_SIZE; i++) begin
        bht[i] <= 2'b01;
      end
    end else if (rdy && br_upd) begin
      if (br_upd_jump) begin
        if (bht[upd_idx] != 2'b11) bht[upd_idx] <= bht[upd_idx] + 2'b01;
      end else begin
        if (bht[upd_idx] != 2'b00) bht[upd_idx] <= bht[upd_idx] - 2'b01;
      end
    end
  end

endmodule

// File: tb/tb_inst_fetcher.sv
// Directed bench for inst_fetcher: an instruction memory model answers every
// fetch combinationally, and each scenario task drives inputs and checks the
// fetch address and issued instruction stream against hand-computed values.
module tb_inst_fetcher;

  logic        clk;
  logic        rst_n;
  logic        rdy;
  logic        rollback;
  logic [31:0] rollback_pc;
  logic        icache_req;
  logic [31:0] icache_addr;
  logic        icache_hit;
  logic [31:0] icache_inst;
  logic        inst_rdy;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_pred_jump;
  logic        rs_full;
  logic        lsb_full;
  logic        rob_full;
  logic        br_upd;
  logic [31:0] br_upd_pc;
  logic        br_upd_jump;

  localparam logic [31:0] ADDI = 32'h00000013;
  localparam logic [31:0] JAL  = 32'h0100006f;  // jal x0, +16
  localparam logic [31:0] BEQ  = 32'h00000463;  // beq x0, x0, +8

  int checks = 0;
  int errors = 0;

  logic [31:0] imem [256];
  logic [31:0] got_pc_q [$];
  logic [31:0] exp_q [$];

  inst_fetcher #(.IQ_DEPTH(4), .BHT_SIZE(256), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst_n(rst_n), .rdy(rdy), .rollback(rollback),
    .rollback_pc(rollback_pc), .icache_req(icache_req),
    .icache_addr(icache_addr), .icache_hit(icache_hit),
    .icache_inst(icache_inst), .inst_rdy(inst_rdy), .inst(inst),
    .inst_pc(inst_pc), .inst_pred_jump(inst_pred_jump), .rs_full(rs_full),
    .lsb_full(lsb_full), .rob_full(rob_full), .br_upd(br_upd),
    .br_upd_pc(br_upd_pc), .br_upd_jump(br_upd_jump)
  );

  assign icache_inst = imem[icache_addr[9:2]];

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset;
    rst_n = 1'b0; rdy = 1'b1; rollback = 1'b0; rollback_pc = 32'h0;
    icache_hit = 1'b0; rs_full = 1'b0; lsb_full = 1'b0; rob_full = 1'b0;
    br_upd = 1'b0; br_upd_pc = 32'h0; br_upd_jump = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // one clock; outputs sampled 1 time unit after the edge, issued PCs logged
  task automatic tick;
    @(posedge clk);
    #1;
    if (inst_rdy) got_pc_q.push_back(inst_pc);
  endtask

  task automatic redirect(input logic [31:0] target);
    rollback = 1'b1; rollback_pc = target; icache_hit = 1'b0;
    tick();
    rollback = 1'b0;
    got_pc_q.delete();
  endtask

  task automatic test_reset;
    do_reset();
    checks++; if (inst_rdy !== 1'b0) begin errors++; $display("FAIL reset_inst_rdy got %0b exp 0", inst_rdy); end
    checks++; if (inst !== 32'h0) begin errors++; $display("FAIL reset_inst got %h exp 0", inst); end
    checks++; if (inst_pc !== 32'h0) begin errors++; $display("FAIL reset_inst_pc got %h exp 0", inst_pc); end
    checks++; if (inst_pred_jump !== 1'b0) begin errors++; $display("FAIL reset_pred got %0b exp 0", inst_pred_jump); end
    checks++; if (icache_addr !== 32'h0) begin errors++; $display("FAIL reset_addr got %h exp 0", icache_addr); end
    checks++; if (icache_req !== 1'b1) begin errors++; $display("FAIL reset_req got %0b exp 1", icache_req); end
  endtask

  task automatic test_sequential;
    do_reset();
    got_pc_q.delete();
    exp_q = '{32'h0, 32'h4, 32'h8};
    icache_hit = 1'b1;
    tick();
    checks++; if (icache_addr !== 32'h4) begin errors++; $display("FAIL seq_addr1 got %h exp 4", icache_addr); end
    checks++; if (inst_rdy !== 1'b0) begin errors++; $display("FAIL seq_latency got %0b exp 0", inst_rdy); end
    tick();
    checks++; if (inst_rdy !== 1'b1 || inst_pc !== 32'h0) begin errors++; $display("FAIL seq_first_issue got rdy=%0b pc=%h exp rdy=1 pc=0", inst_rdy, inst_pc); end
    checks++; if (inst !== ADDI || inst_pred_jump !== 1'b0) begin errors++; $display("FAIL seq_first_inst got %h/%0b exp %h/0", inst, inst_pred_jump, ADDI); end
    checks++; if (icache_addr !== 32'h8) begin errors++; $display("FAIL seq_addr2 got %h exp 8", icache_addr); end
    tick();
    icache_hit = 1'b0;
    repeat (4) tick();
    checks++; if (got_pc_q.size() !== exp_q.size()) begin errors++; $display("FAIL seq_count got %0d exp %0d", got_pc_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < got_pc_q.size()) begin
        checks++; if (got_pc_q[i] !== exp_q[i]) begin errors++; $display("FAIL seq_pc[%0d] got %h exp %h", i, got_pc_q[i], exp_q[i]); end
      end
    end
  endtask

  task automatic test_jal_beq;
    do_reset();
    imem[4]  = JAL;
    imem[16] = BEQ;
    redirect(32'h10);
    icache_hit = 1'b1;
    tick();
    checks++; if (icache_addr !== 32'h20) begin errors++; $display("FAIL jal_target got %h exp 20", icache_addr); end
    tick();
    checks++; if (inst_rdy !== 1'b1 || inst_pc !== 32'h10 || inst_pred_jump !== 1'b1) begin errors++; $display("FAIL jal_issue got rdy=%0b pc=%h pred=%0b exp 1/10/1", inst_rdy, inst_pc, inst_pred_jump); end
    checks++; if (inst !== JAL) begin errors++; $display("FAIL jal_inst got %h exp %h", inst, JAL); end
    redirect(32'h40);
    icache_hit = 1'b1;
    tick();
    checks++; if (icache_addr !== 32'h44) begin errors++; $display("FAIL beq_nt_addr got %h exp 44", icache_addr); end
    tick();
    checks++; if (inst_pc !== 32'h40 || inst_pred_jump !== 1'b0) begin errors++; $display("FAIL beq_nt_issue got pc=%h pred=%0b exp 40/0", inst_pc, inst_pred_jump); end
  endtask

  task automatic fetch_beq_check(input logic [31:0] exp_addr, input logic exp_pred, input int tag);
    redirect(32'h40);
    icache_hit = 1'b1;
    tick();
    checks++; if (icache_addr !== exp_addr) begin errors++; $display("FAIL bht_addr_%0d got %h exp %h", tag, icache_addr, exp_addr); end
    tick();
    checks++; if (inst_pc !== 32'h40 || inst_pred_jump !== exp_pred) begin errors++; $display("FAIL bht_pred_%0d got pc=%h pred=%0b exp 40/%0b", tag, inst_pc, inst_pred_jump, exp_pred); end
    icache_hit = 1'b0;
  endtask

  task automatic test_bht;
    redirect(32'h40);
    br_upd = 1'b1; br_upd_pc = 32'h40; br_upd_jump = 1'b1;
    tick(); tick();                      // 01 -> 10 -> 11
    br_upd = 1'b0;
    fetch_beq_check(32'h48, 1'b1, 0);
    redirect(32'h40);
    br_upd = 1'b1; br_upd_jump = 1'b1; tick();   // saturates at 11
    br_upd_jump = 1'b0; tick();                  // 11 -> 10
    br_upd = 1'b0;
    fetch_beq_check(32'h48, 1'b1, 1);
    redirect(32'h40);
    br_upd = 1'b1; br_upd_jump = 1'b0; tick();   // 10 -> 01
    br_upd = 1'b0;
    fetch_beq_check(32'h44, 1'b0, 2);
  endtask

  task automatic test_backpressure;
    redirect(32'h200);
    rob_full = 1'b1;
    icache_hit = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++; if (inst_rdy !== 1'b0) begin errors++; $display("FAIL bp_stall_rdy[%0d] got %0b exp 0", i, inst_rdy); end
    end
    checks++; if (icache_req !== 1'b0) begin errors++; $display("FAIL bp_full_req got %0b exp 0", icache_req); end
    checks++; if (icache_addr !== 32'h210) begin errors++; $display("FAIL bp_full_addr got %h exp 210", icache_addr); end
    rob_full = 1'b0;
    icache_hit = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (i < 4) begin
        checks++; if (inst_rdy !== 1'b1 || inst_pc !== 32'h200 + 32'(4 * i)) begin errors++; $display("FAIL bp_drain[%0d] got rdy=%0b pc=%h exp 1/%h", i, inst_rdy, inst_pc, 32'h200 + 32'(4 * i)); end
      end else begin
        checks++; if (inst_rdy !== 1'b0) begin errors++; $display("FAIL bp_drain_end got %0b exp 0", inst_rdy); end
      end
    end
  endtask

  task automatic test_rollback;
    redirect(32'h300);
    rob_full = 1'b1;
    icache_hit = 1'b1;
    repeat (3) tick();
    rollback = 1'b1; rollback_pc = 32'h100; rob_full = 1'b0;
    tick();
    checks++; if (inst_rdy !== 1'b0) begin errors++; $display("FAIL rb_rdy got %0b exp 0", inst_rdy); end
    checks++; if (icache_addr !== 32'h100) begin errors++; $display("FAIL rb_addr got %h exp 100", icache_addr); end
    rollback = 1'b0;
    icache_hit = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (inst_rdy !== 1'b0) begin errors++; $display("FAIL rb_stale[%0d] got rdy=%0b pc=%h exp 0", i, inst_rdy, inst_pc); end
    end
    icache_hit = 1'b1;
    tick();
    tick();
    checks++; if (inst_rdy !== 1'b1 || inst_pc !== 32'h100) begin errors++; $display("FAIL rb_resume got rdy=%0b pc=%h exp 1/100", inst_rdy, inst_pc); end
    icache_hit = 1'b0;
    repeat (3) tick();
  endtask

  task automatic test_stall_and_async_reset;
    redirect(32'h380);
    exp_q.delete();
    for (int i = 0; i < 6; i++) exp_q.push_back(32'h380 + 32'(4 * i));
    icache_hit = 1'b1;
    repeat (3) tick();
    rdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (inst_rdy !== 1'b0 || icache_req !== 1'b0) begin errors++; $display("FAIL stall_rdy_req[%0d] got %0b/%0b exp 0/0", i, inst_rdy, icache_req); end
      checks++; if (icache_addr !== 32'h38c) begin errors++; $display("FAIL stall_pc[%0d] got %h exp 38c", i, icache_addr); end
    end
    rdy = 1'b1;
    repeat (3) tick();
    icache_hit = 1'b0;
    repeat (5) tick();
    checks++; if (got_pc_q.size() !== exp_q.size()) begin errors++; $display("FAIL stall_count got %0d exp %0d", got_pc_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < got_pc_q.size()) begin
        checks++; if (got_pc_q[i] !== exp_q[i]) begin errors++; $display("FAIL stall_pc_seq[%0d] got %h exp %h", i, got_pc_q[i], exp_q[i]); end
      end
    end
    // reset in the middle of a running stream
    icache_hit = 1'b1;
    repeat (3) tick();
    rst_n = 1'b0;
    #1;
    checks++; if (inst_rdy !== 1'b0 || inst !== 32'h0 || inst_pc !== 32'h0 || inst_pred_jump !== 1'b0) begin errors++; $display("FAIL async_rst_out got %0b/%h/%h/%0b exp 0/0/0/0", inst_rdy, inst, inst_pc, inst_pred_jump); end
    checks++; if (icache_addr !== 32'h0) begin errors++; $display("FAIL async_rst_pc got %h exp 0", icache_addr); end
    repeat (2) @(posedge clk);
    #1;
    checks++; if (icache_addr !== 32'h0) begin errors++; $display("FAIL rst_hit_ignored got %h exp 0", icache_addr); end
    icache_hit = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (inst_rdy !== 1'b0) begin errors++; $display("FAIL rst_queue_empty[%0d] got %0b exp 0", i, inst_rdy); end
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) imem[i] = ADDI;
    test_reset();
    test_sequential();
    test_jal_beq();
    test_bht();
    test_backpressure();
    test_rollback();
    test_stall_and_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
